// File: rtl/frame_st_source.sv
// Ping-pong frame buffer that captures ADC sample frames and replays each
// complete frame as one Avalon-ST packet (readyLatency 0, registered outputs).
module frame_st_source #(
  parameter int WORDS_PER_FRAME = 320,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              sample_sof,
  output logic [DATA_W-1:0] data_out_data,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              data_out_empty,
  output logic              data_out_startofpacket,
  output logic              data_out_endofpacket,
  output logic              frame_dropped,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SEND     = 2'd2
  } rd_state_t;

  logic [DATA_W-1:0] mem_q [2][WORDS_PER_FRAME];

  rd_state_t         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_active_q, wr_active_d;
  logic [1:0]        full_q, full_d;
  logic              frame_dropped_q, frame_dropped_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic              frame_done;
  logic              pkt_done;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_word;

  // Write side: frame start/restart, drop detection and bank completion.
  always_comb begin
    wr_bank_d       = wr_bank_q;
    wr_idx_d        = wr_idx_q;
    wr_active_d     = wr_active_q;
    frame_dropped_d = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = wr_idx_q;
    frame_done      = 1'b0;
    if (sample_valid) begin
      if (sample_sof) begin
        if (full_q[wr_bank_q]) begin
          frame_dropped_d = 1'b1;
          wr_active_d     = 1'b0;
          wr_idx_d        = '0;
        end else begin
          wr_en       = 1'b1;
          wr_addr     = '0;
          wr_active_d = 1'b1;
          wr_idx_d    = IDX_W'(1);
          frame_done  = (LAST_IDX == '0);
        end
      end else if (wr_active_q) begin
        wr_en   = 1'b1;
        wr_addr = wr_idx_q;
        if (wr_idx_q == LAST_IDX) begin
          frame_done = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end else begin
        wr_en = 1'b0;
      end
    end else begin
      wr_en = 1'b0;
    end
    if (frame_done) begin
      wr_bank_d   = ~wr_bank_q;
      wr_idx_d    = '0;
      wr_active_d = 1'b0;
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  // Full flags: a completed write and a finished packet on the other bank may coincide.
  always_comb begin
    full_d = full_q;
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d[wr_bank_q] = full_q[wr_bank_q];
    end
    if (pkt_done) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d[rd_bank_q] = full_d[rd_bank_q];
    end
  end

  // Frame buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_addr] <= sample_data;
    end
  end

  assign rd_addr = (state_q == ST_PREFETCH) ? '0 : rd_idx_q;
  assign rd_word = mem_q[rd_bank_q][rd_addr];
  assign pkt_done = (state_q == ST_SEND) && valid_q && data_out_ready && eop_q;

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = full_q[rd_bank_q] ? ST_PREFETCH : ST_IDLE;
      ST_PREFETCH: state_d = ST_SEND;
      ST_SEND:     state_d = pkt_done ? ST_IDLE : ST_SEND;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Read FSM outputs: next stream word and flags, loaded one beat ahead.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    rd_idx_d    = rd_idx_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
      ST_PREFETCH: begin
        data_d   = rd_word;
        valid_d  = 1'b1;
        sop_d    = 1'b1;
        eop_d    = (LAST_IDX == '0);
        rd_idx_d = (LAST_IDX == '0) ? '0 : IDX_W'(1);
      end
      ST_SEND: begin
        if (valid_q && data_out_ready) begin
          if (eop_q) begin
            valid_d     = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            rd_bank_d   = ~rd_bank_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            data_d = rd_word;
            sop_d  = 1'b0;
            eop_d  = (rd_idx_q == LAST_IDX);
            if (rd_idx_q != LAST_IDX) begin
              rd_idx_d = rd_idx_q + IDX_W'(1);
            end else begin
              rd_idx_d = rd_idx_q;
            end
          end
        end else begin
          data_d = data_q;
        end
      end
      default: begin
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
      end
    endcase
  end

  // Datapath and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q       <= 1'b0;
      wr_idx_q        <= '0;
      wr_active_q     <= 1'b0;
      full_q          <= 2'b00;
      frame_dropped_q <= 1'b0;
      rd_bank_q       <= 1'b0;
      rd_idx_q        <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      sop_q           <= 1'b0;
      eop_q           <= 1'b0;
      frame_cnt_q     <= 16'd0;
    end else begin
      wr_bank_q       <= wr_bank_d;
      wr_idx_q        <= wr_idx_d;
      wr_active_q     <= wr_active_d;
      full_q          <= full_d;
      frame_dropped_q <= frame_dropped_d;
      rd_bank_q       <= rd_bank_d;
      rd_idx_q        <= rd_idx_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      sop_q           <= sop_d;
      eop_q           <= eop_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign data_out_data          = data_q;
  assign data_out_valid         = valid_q;
  assign data_out_startofpacket = sop_q;
  assign data_out_endofpacket   = eop_q;
  assign data_out_empty         = 1'b0;
  assign frame_dropped          = frame_dropped_q;
  assign frame_cnt              = frame_cnt_q;

endmodule

// File: tb/tb_frame_st_source.sv
// Directed self-checking bench for frame_st_source (320-word frames).
module tb_frame_st_source;

  logic        clk;
  logic        rst;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_sof;
  logic [15:0] data_out_data;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        data_out_empty;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic        frame_dropped;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int drop_cycles = 0;

  int q_data[$];
  bit q_sop[$];
  bit q_eop[$];
  int first_cyc, last_cyc, hold_err;
  bit drain_to;

  frame_st_source #(.WORDS_PER_FRAME(320), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_sof(sample_sof),
    .data_out_data(data_out_data), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_empty(data_out_empty),
    .data_out_startofpacket(data_out_startofpacket),
    .data_out_endofpacket(data_out_endofpacket),
    .frame_dropped(frame_dropped), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_dropped === 1'b1) drop_cycles++;
  end

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_sof   = (i == 0);
      sample_data  = 16'(base + i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    sample_sof   = 1'b0;
  endtask

  task automatic send_nosof(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_sof   = 1'b0;
      sample_data  = 16'(base + i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  // Collects transfers; ready is left at its last value so a pending beat completes.
  task automatic drain(input int pkts, input bit toggle, input int stop_beats, input int budget);
    int cyc, eops;
    bit have_prev;
    logic [15:0] pd;
    logic ps, pe;
    q_data.delete(); q_sop.delete(); q_eop.delete();
    cyc = 0; eops = 0; have_prev = 1'b0; hold_err = 0; first_cyc = -1; last_cyc = -1;
    pd = '0; ps = 1'b0; pe = 1'b0;
    while (eops < pkts && q_data.size() < stop_beats && cyc < budget) begin
      @(negedge clk);
      cyc++;
      data_out_ready = toggle ? cyc[0] : 1'b1;
      if (have_prev && (data_out_valid !== 1'b1 || data_out_data !== pd ||
                        data_out_startofpacket !== ps || data_out_endofpacket !== pe))
        hold_err++;
      have_prev = data_out_valid && !data_out_ready;
      pd = data_out_data; ps = data_out_startofpacket; pe = data_out_endofpacket;
      if (data_out_valid && data_out_ready) begin
        q_data.push_back(int'(data_out_data));
        q_sop.push_back(data_out_startofpacket);
        q_eop.push_back(data_out_endofpacket);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (data_out_endofpacket) eops++;
      end
    end
    drain_to = (eops < pkts) && (q_data.size() < stop_beats);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out_valid, data_out_startofpacket, data_out_endofpacket, frame_dropped, data_out_empty} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {data_out_valid, data_out_startofpacket, data_out_endofpacket, frame_dropped, data_out_empty});
    end
    checks++;
    if (data_out_data !== 16'd0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_data_cnt got data=%0d cnt=%0d want 0 0", data_out_data, frame_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d0;
    d0 = drop_cycles;
    data_out_ready = 1'b0;
    send_frame(320, 0);
    @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b want=0 one cycle after last write", data_out_valid);
    end
    @(negedge clk);
    checks++;
    if ({data_out_valid, data_out_startofpacket, data_out_data} !== {1'b1, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL basic_first_beat_latency got valid=%b sop=%b data=%0d want 1 1 0",
               data_out_valid, data_out_startofpacket, data_out_data);
    end
    drain(1, 1'b0, 100000, 1000);
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 320) begin
      failures++;
      $display("FAIL basic_beats got=%0d want=320 timeout=%b", q_data.size(), drain_to);
    end
    checks++;
    if (last_cyc - first_cyc + 1 !== 320) begin
      failures++;
      $display("FAIL basic_consecutive got span=%0d want=320", last_cyc - first_cyc + 1);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i]} !== {i, (i == 0), (i == 319)}) begin
        failures++;
        $display("FAIL basic_beat%0d got data=%0d sop=%b eop=%b want %0d %b %b",
                 i, q_data[i], q_sop[i], q_eop[i], i, (i == 0), (i == 319));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd1 || data_out_empty !== 1'b0) begin
      failures++;
      $display("FAIL basic_frame_cnt got cnt=%0d empty=%b want 1 0", frame_cnt, data_out_empty);
    end
    checks++;
    if (drop_cycles - d0 !== 0) begin
      failures++;
      $display("FAIL basic_no_drop got=%0d want=0", drop_cycles - d0);
    end
  endtask

  task automatic test_backpressure();
    send_frame(320, 1000);
    drain(1, 1'b1, 100000, 2000);
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 320) begin
      failures++;
      $display("FAIL bp_beats got=%0d want=320 timeout=%b", q_data.size(), drain_to);
    end
    checks++;
    if (hold_err !== 0) begin
      failures++;
      $display("FAIL bp_hold_stable got=%0d unstable cycles want=0", hold_err);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i]} !== {1000 + i, (i == 0), (i == 319)}) begin
        failures++;
        $display("FAIL bp_beat%0d got data=%0d sop=%b eop=%b want %0d", i, q_data[i], q_sop[i], q_eop[i], 1000 + i);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL bp_frame_cnt got=%0d want=2", frame_cnt);
    end
  endtask

  task automatic test_overflow();
    int d0;
    d0 = drop_cycles;
    data_out_ready = 1'b0;
    send_frame(320, 2000);
    send_frame(320, 3000);
    send_frame(320, 4000);
    repeat (3) @(negedge clk);
    checks++;
    if (drop_cycles - d0 !== 1) begin
      failures++;
      $display("FAIL ovf_drop_pulses got=%0d want=1", drop_cycles - d0);
    end
    checks++;
    if ({data_out_valid, data_out_startofpacket, data_out_data} !== {1'b1, 1'b1, 16'd2000}) begin
      failures++;
      $display("FAIL ovf_held_first got valid=%b sop=%b data=%0d want 1 1 2000",
               data_out_valid, data_out_startofpacket, data_out_data);
    end
    drain(2, 1'b0, 100000, 2000);
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 640) begin
      failures++;
      $display("FAIL ovf_beats got=%0d want=640 timeout=%b", q_data.size(), drain_to);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== ((i < 320) ? 2000 + i : 3000 + i - 320)) begin
        failures++;
        $display("FAIL ovf_beat%0d got=%0d want=%0d", i, q_data[i], (i < 320) ? 2000 + i : 3000 + i - 320);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd4 || data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_frame_cnt got cnt=%0d valid=%b want 4 0", frame_cnt, data_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = drop_cycles;
    send_frame(320, 10000);
    fork
      drain(3, 1'b0, 100000, 3000);
      begin
        repeat (2) @(negedge clk);
        send_frame(320, 11000);
        send_frame(320, 12000);
      end
    join
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 960) begin
      failures++;
      $display("FAIL b2b_beats got=%0d want=960 timeout=%b", q_data.size(), drain_to);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i]} !== {10000 + (i / 320) * 1000 + (i % 320), (i % 320 == 0), (i % 320 == 319)}) begin
        failures++;
        $display("FAIL b2b_beat%0d got data=%0d sop=%b eop=%b want %0d", i, q_data[i], q_sop[i], q_eop[i],
                 10000 + (i / 320) * 1000 + (i % 320));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (drop_cycles - d0 !== 0 || frame_cnt !== 16'd7) begin
      failures++;
      $display("FAIL b2b_drop_cnt got drops=%0d cnt=%0d want 0 7", drop_cycles - d0, frame_cnt);
    end
  endtask

  task automatic test_restart();
    int d0, vcount;
    d0 = drop_cycles;
    send_frame(100, 5000);
    send_frame(320, 6000);
    drain(1, 1'b0, 100000, 1000);
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 320) begin
      failures++;
      $display("FAIL restart_beats got=%0d want=320 timeout=%b", q_data.size(), drain_to);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 6000 + i) begin
        failures++;
        $display("FAIL restart_beat%0d got=%0d want=%0d", i, q_data[i], 6000 + i);
      end
    end
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (data_out_valid) vcount++;
    end
    checks++;
    if (vcount !== 0 || drop_cycles - d0 !== 0 || frame_cnt !== 16'd8) begin
      failures++;
      $display("FAIL restart_single_pkt got extra_valid=%0d drops=%0d cnt=%0d want 0 0 8",
               vcount, drop_cycles - d0, frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(320, 7000);
    drain(1, 1'b0, 150, 1000);
    @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b1 || data_out_data !== 16'd7150) begin
      failures++;
      $display("FAIL rstmid_pre got valid=%b data=%0d want 1 7150", data_out_valid, data_out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({data_out_valid, data_out_startofpacket, data_out_endofpacket} !== 3'b000 ||
        frame_cnt !== 16'd0 || data_out_data !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_async got valid=%b sop=%b eop=%b cnt=%0d data=%0d want 0 0 0 0 0",
               data_out_valid, data_out_startofpacket, data_out_endofpacket, frame_cnt, data_out_data);
    end
    data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_nosof(5, 9000);
    send_frame(320, 8000);
    drain(1, 1'b0, 100000, 1000);
    checks++;
    if (drain_to !== 1'b0 || q_data.size() !== 320) begin
      failures++;
      $display("FAIL rstmid_beats got=%0d want=320 timeout=%b", q_data.size(), drain_to);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_sop[i], q_eop[i]} !== {8000 + i, (i == 0), (i == 319)}) begin
        failures++;
        $display("FAIL rstmid_beat%0d got data=%0d sop=%b eop=%b want %0d", i, q_data[i], q_sop[i], q_eop[i], 8000 + i);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_frame_cnt got=%0d want=1", frame_cnt);
    end
  endtask

  task automatic test_wrap();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h want=ffff", frame_cnt);
    end
    send_frame(320, 20);
    drain(1, 1'b0, 100000, 1000);
    repeat (2) @(negedge clk);
    checks++;
    if (drain_to !== 1'b0 || frame_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_cnt got=%h want=0000 timeout=%b", frame_cnt, drain_to);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    sample_data = 16'd0;
    sample_valid = 1'b0;
    sample_sof = 1'b0;
    data_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
